// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_ctrl
//  Purpose  : Word-addressed data-memory controller for the LW/SW stage.
//             It accepts level-held read and write requests, answers reads
//             after a fixed latency, and gives one mem_ready pulse per access.
//             A rising edge on write_mf streams the whole array out, one word
//             per cycle.
//  Ports    : clk, rst (async, active-high)
//             mem_addr/mem_wdata/mem_wen/mem_ren  - request side
//             mem_rdata/mem_ready/addr_err/busy   - response side
//             write_mf                            - dump request (edge)
//             dump_valid/dump_addr/dump_data/dump_done - dump stream
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              mem_wen,
  input  logic              mem_ren,
  input  logic              write_mf,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              addr_err,
  output logic              busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [31:0]       dump_data,
  output logic              dump_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR_ACK  = 3'd2,
    RELEASE = 3'd3,
    DUMP    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              oor_q, oor_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              pend_q, pend_d;
  logic              mf_q, mf_d;
  logic [ADDR_W-1:0] dump_idx_q, dump_idx_d;
  logic              dump_done_q, dump_done_d;

  logic [31:0]       mem_array [DEPTH];
  logic              mf_rise;
  logic              req_oor;
  logic              mem_we;

  assign mf_rise = write_mf & ~mf_q;
  assign req_oor = |mem_addr[31:ADDR_W];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    oor_d       = oor_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    err_d       = 1'b0;
    pend_d      = pend_q;
    mf_d        = write_mf;
    dump_idx_d  = dump_idx_q;
    dump_done_d = 1'b0;
    mem_we      = 1'b0;

    // An edge seen while an access is in flight is remembered; in IDLE it is
    // acted on directly and during DUMP it is dropped.
    if (mf_rise && (state_q != IDLE) && (state_q != DUMP)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pend_q || mf_rise) begin
          state_d    = DUMP;
          dump_idx_d = '0;
          pend_d     = 1'b0;
        end else if (mem_wen) begin
          idx_d   = mem_addr[ADDR_W-1:0];
          oor_d   = req_oor;
          mem_we  = ~req_oor;
          state_d = WR_ACK;
        end else if (mem_ren) begin
          idx_d   = mem_addr[ADDR_W-1:0];
          oor_d   = req_oor;
          cnt_d   = 4'(RD_LAT - 1);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = oor_q ? 32'h0 : mem_array[idx_q];
          ready_d = 1'b1;
          err_d   = oor_q;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_ACK: begin
        ready_d = 1'b1;
        err_d   = oor_q;
        state_d = RELEASE;
      end
      RELEASE: begin
        // Hold here until the requester lets go so a level-held request is
        // not executed a second time.
        if (!mem_ren && !mem_wen) begin
          state_d = IDLE;
        end
      end
      DUMP: begin
        if (dump_idx_q == LAST_IDX) begin
          dump_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          dump_idx_d = dump_idx_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      oor_q       <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      mf_q        <= 1'b0;
      dump_idx_q  <= '0;
      dump_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      oor_q       <= oor_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      mf_q        <= mf_d;
      dump_idx_q  <= dump_idx_d;
      dump_done_q <= dump_done_d;
    end
  end

  // Storage is deliberately outside the reset domain: contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_array[mem_addr[ADDR_W-1:0]] <= mem_wdata;
    end
  end

  assign mem_rdata  = rdata_q;
  assign mem_ready  = ready_q;
  assign addr_err   = err_q;
  assign busy       = (state_q != IDLE);
  assign dump_valid = (state_q == DUMP);
  assign dump_addr  = (state_q == DUMP) ? dump_idx_q : '0;
  assign dump_data  = (state_q == DUMP) ? mem_array[dump_idx_q] : 32'h0;
  assign dump_done  = dump_done_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_ctrl
//  Purpose  : Self-checking bench for data_mem_ctrl. Expected access results
//             are queued when a request is driven and checked when mem_ready
//             appears; dump words are checked against a local array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  localparam int ADDR_W = 5;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_wen;
  logic              mem_ren;
  logic              write_mf;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic              addr_err;
  logic              busy;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_addr;
  logic [31:0]       dump_data;
  logic              dump_done;

  data_mem_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .write_mf   (write_mf),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .addr_err   (addr_err),
    .busy       (busy),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        is_rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model [DEPTH];
  int          checks   = 0;
  int          failures = 0;
  int          dump_cnt = 0;
  int          dumps    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Response / dump monitor
  always @(negedge clk) begin
    if (!rst && mem_ready) begin
      chk("ready_has_pending_access", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("addr_err", 32'(addr_err), 32'(mon_e.err));
        if (mon_e.is_rd) chk("rdata", mem_rdata, mon_e.rdata);
      end
    end
    if (!rst && addr_err) chk("err_with_ready", 32'(mem_ready), 32'd1);
    if (!rst && dump_valid) begin
      chk("dump_no_pending_access", 32'(sb.size() == 0), 32'd1);
      chk("dump_addr", 32'(dump_addr), 32'(dump_cnt));
      chk("dump_data", dump_data, model[dump_cnt % DEPTH]);
      dump_cnt++;
    end
    if (!rst && dump_done) begin
      chk("dump_len", 32'(dump_cnt), 32'(DEPTH));
      dump_cnt = 0;
      dumps++;
    end
  end

  task automatic access(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input bit mf_pulse);
    int   n;
    exp_t e;
    logic oor;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_before_access", 32'(busy), 32'd0);
    oor     = |addr[31:ADDR_W];
    e.is_rd = !we && re;
    e.err   = oor;
    e.rdata = oor ? 32'h0 : model[addr[ADDR_W-1:0]];
    if (we && !oor) model[addr[ADDR_W-1:0]] = wdata;
    sb.push_back(e);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wen   = we;
    mem_ren   = re;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        // Address and data must be ignored once the request is accepted.
        mem_addr  = ~addr;
        mem_wdata = ~wdata;
      end
      if (mf_pulse) write_mf = (n == 1);
    end while (!mem_ready && n < 20);
    write_mf = 1'b0;
    chk("latency", 32'(n - 1), we ? 32'd1 : 32'(RD_LAT));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("held_in_release", 32'(busy), 32'd1);
    end
    mem_wen = 1'b0;
    mem_ren = 1'b0;
    @(negedge clk);
    chk("release_exit", 32'(busy), 32'd0);
  endtask

  task automatic wait_dump(input int target);
    int n;
    n = 0;
    while (dumps < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("dump_completed", 32'(dumps), 32'(target));
  endtask

  initial begin
    rst       = 1'b1;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    write_mf  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdata",      mem_rdata,          32'h0);
    chk("rst_ready",      32'(mem_ready),     32'd0);
    chk("rst_err",        32'(addr_err),      32'd0);
    chk("rst_busy",       32'(busy),          32'd0);
    chk("rst_dump_valid", 32'(dump_valid),    32'd0);
    chk("rst_dump_addr",  32'(dump_addr),     32'd0);
    chk("rst_dump_data",  dump_data,          32'h0);
    chk("rst_dump_done",  32'(dump_done),     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic write then read
    access(1'b1, 1'b0, 32'd3, 32'hDEADBEEF, 0, 1'b0);
    access(1'b0, 1'b1, 32'd3, 32'h0, 0, 1'b0);
    // Held read: one pulse, stays in RELEASE
    access(1'b0, 1'b1, 32'd3, 32'h0, 5, 1'b0);
    // Simultaneous wen/ren is a write
    access(1'b1, 1'b1, 32'd7, 32'h5, 0, 1'b0);
    access(1'b0, 1'b1, 32'd7, 32'h0, 0, 1'b0);
    chk("rdata_hold_after_read", mem_rdata, 32'h5);

    // Fill with i*3
    for (int i = 0; i < DEPTH; i++) access(1'b1, 1'b0, 32'(i), 32'(i * 3), 0, 1'b0);

    // Out-of-range write and read, then dump to confirm array unchanged
    access(1'b1, 1'b0, 32'h20, 32'hFFFF_FFFF, 0, 1'b0);
    access(1'b0, 1'b1, 32'h20, 32'h0, 0, 1'b0);
    write_mf = 1'b1;
    @(negedge clk);
    write_mf = 1'b0;
    wait_dump(1);

    // Dump request during a read: read finishes, then dump
    access(1'b0, 1'b1, 32'd5, 32'h0, 0, 1'b1);
    wait_dump(2);
    chk("rdata_after_dump", mem_rdata, 32'd15);

    // Reset in the middle of a read
    while (busy) @(negedge clk);
    mem_addr = 32'd9;
    mem_ren  = 1'b1;
    @(negedge clk);
    chk("rd_wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy",  32'(busy),      32'd0);
    chk("midrst_rdata", mem_rdata,      32'h0);
    chk("midrst_ready", 32'(mem_ready), 32'd0);
    mem_ren = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_ready_after_rst", 32'(mem_ready), 32'd0);
    end
    access(1'b0, 1'b1, 32'd9, 32'h0, 0, 1'b0);
    access(1'b1, 1'b0, 32'd9, 32'h1234_5678, 0, 1'b0);
    access(1'b0, 1'b1, 32'd9, 32'h0, 2, 1'b0);
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
